// File: rtl/button_conditioner.sv
// Push-button front end: synchronizes and debounces three raw buttons, emits
// one-cycle press pulses, and auto-repeats the up/down buttons while held.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 20000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  input  logic btn_mid_raw,
  output logic up,
  output logic down,
  output logic modify,
  output logic up_level,
  output logic down_level,
  output logic mid_level
);

  localparam int unsigned NB       = 3;
  localparam int unsigned DB_MAX   = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam int unsigned HOLD_MAX = (HOLD_CYCLES > 1) ? HOLD_CYCLES - 1 : 0;
  localparam int unsigned REP_MAX  = (REPEAT_CYCLES > 1) ? REPEAT_CYCLES - 1 : 0;
  localparam int unsigned RPT_BIG  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned DB_W     = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(64'(DEBOUNCE_CYCLES) + 64'd1);
  localparam int unsigned RPT_W    = (RPT_BIG < 2) ? 1 : $clog2(64'(RPT_BIG) + 64'd1);

  typedef logic [DB_W-1:0]  db_cnt_t;
  typedef logic [RPT_W-1:0] rpt_cnt_t;

  localparam db_cnt_t  DB_LAST   = db_cnt_t'(DB_MAX);
  localparam rpt_cnt_t HOLD_LAST = rpt_cnt_t'(HOLD_MAX);
  localparam rpt_cnt_t REP_LAST  = rpt_cnt_t'(REP_MAX);

  typedef enum logic {RPT_HOLD, RPT_REPEAT} rpt_state_t;

  logic [NB-1:0] raw, sync1, sync2, stable, level, press;
  db_cnt_t       db_cnt [NB];
  logic [1:0]    held, rpt_fire;
  rpt_state_t    rpt_state [2];
  rpt_state_t    rpt_next  [2];
  rpt_cnt_t      rpt_cnt   [2];

  // Bit order throughout: 0 = up, 1 = down, 2 = middle.
  assign raw = {btn_mid_raw, btn_down_raw, btn_up_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level <= stable;
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press   = stable & ~level;
  // Repeat runs only while exactly one of up/down is held.
  assign held[0] = level[0] & ~level[1];
  assign held[1] = level[1] & ~level[0];

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      rpt_next[i] = rpt_state[i];
      rpt_fire[i] = 1'b0;
      if (!held[i]) begin
        rpt_next[i] = RPT_HOLD;
      end else begin
        case (rpt_state[i])
          RPT_HOLD: begin
            if (rpt_cnt[i] == HOLD_LAST) begin
              rpt_fire[i] = 1'b1;
              rpt_next[i] = RPT_REPEAT;
            end
          end
          RPT_REPEAT: begin
            if (rpt_cnt[i] == REP_LAST) rpt_fire[i] = 1'b1;
          end
          default: rpt_next[i] = RPT_HOLD;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        rpt_state[i] <= RPT_HOLD;
        rpt_cnt[i]   <= '0;
      end
      up     <= 1'b0;
      down   <= 1'b0;
      modify <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        rpt_state[i] <= rpt_next[i];
        if (!held[i] || rpt_fire[i]) begin
          rpt_cnt[i] <= '0;
        end else if (rpt_cnt[i] != '1) begin
          rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
        end
      end
      // Up wins any same-cycle collision so the outputs never both pulse.
      up     <= press[0] | rpt_fire[0];
      down   <= (press[1] | rpt_fire[1]) & ~(press[0] | rpt_fire[0]);
      modify <= press[2];
    end
  end

  assign up_level   = level[0];
  assign down_level = level[1];
  assign mid_level  = level[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized presses,
// compared each cycle against a run-length/age based reference model.
module tb_button_conditioner;
  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up_raw = 1'b0, btn_down_raw = 1'b0, btn_mid_raw = 1'b0;
  logic up, down, modify, up_level, down_level, mid_level;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw), .btn_mid_raw(btn_mid_raw),
    .up(up), .down(down), .modify(modify),
    .up_level(up_level), .down_level(down_level), .mid_level(mid_level)
  );

  always #5 clk = ~clk;

  logic [5:0] obs;
  assign obs = {up, down, modify, up_level, down_level, mid_level};

  // Reference model: raw seen 2 edges late, level accepted after D mismatching
  // samples in a row, repeats by age since exclusive hold began.
  logic [2:0] m_h1, m_h2, m_stable, m_level;
  int         m_run [3];
  int         m_age [2];
  logic [5:0] exp_v = '0;

  function automatic bit rep_due(input int a);
    return (a == H) || (a > H && ((a - H) % R) == 0);
  endfunction

  task model_edge();
    logic [2:0] raw_now, st_old, lv_old, press;
    logic [1:0] ex, rep;
    logic       syn, e_up, e_down;
    raw_now = {btn_mid_raw, btn_down_raw, btn_up_raw};
    if (rst) begin
      m_h1 = '0; m_h2 = '0; m_stable = '0; m_level = '0; exp_v = '0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      m_age[0] = 0; m_age[1] = 0;
    end else begin
      st_old = m_stable;
      lv_old = m_level;
      ex[0] = lv_old[0] & ~lv_old[1];
      ex[1] = lv_old[1] & ~lv_old[0];
      for (int b = 0; b < 3; b++) begin
        syn = m_h2[b];
        m_h2[b] = m_h1[b];
        m_h1[b] = raw_now[b];
        if (syn != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_stable[b] = ~m_stable[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        press[b] = st_old[b] & ~lv_old[b];
      end
      m_level = st_old;
      for (int k = 0; k < 2; k++) begin
        m_age[k] = ex[k] ? m_age[k] + 1 : 0;
        rep[k] = ex[k] & rep_due(m_age[k]);
      end
      e_up   = press[0] | rep[0];
      e_down = (press[1] | rep[1]) & ~e_up;
      exp_v  = {e_up, e_down, press[2], m_level[0], m_level[1], m_level[2]};
    end
  endtask

  task tick();
    model_edge();
    @(negedge clk);
  endtask

  task settle(input int n);
    btn_up_raw = 0; btn_down_raw = 0; btn_mid_raw = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL settle obs=%b exp=%b cycle=%0d", obs, exp_v, i);
      end
    end
  endtask

  task test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      btn_up_raw = 1'($urandom); btn_down_raw = 1'($urandom); btn_mid_raw = 1'($urandom);
      tick();
      checks++;
      if (obs !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs obs=%b exp=000000 cycle=%0d", obs, i);
      end
    end
    rst = 0;
    settle(10);
  endtask

  task test_clean_press();
    for (int i = 0; i < 30; i++) begin
      btn_up_raw = 1;
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_model obs=%b exp=%b edge=%0d", obs, exp_v, i);
      end
      checks++;
      if (up !== (i == 6 || i == 16 || i == 21 || i == 26)) begin
        errors++;
        $display("FAIL clean_up_pulse got=%b edge=%0d", up, i);
      end
      checks++;
      if (up_level !== (i >= 6)) begin
        errors++;
        $display("FAIL clean_up_level got=%b exp=%b edge=%0d", up_level, (i >= 6), i);
      end
    end
    settle(20);
  endtask

  task test_glitch();
    for (int i = 0; i < 15; i++) begin
      btn_mid_raw = (i < 3);
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL glitch_model obs=%b exp=%b edge=%0d", obs, exp_v, i);
      end
      checks++;
      if (modify !== 1'b0 || mid_level !== 1'b0) begin
        errors++;
        $display("FAIL glitch_mid modify=%b mid_level=%b exp=0 edge=%0d", modify, mid_level, i);
      end
    end
    settle(5);
  endtask

  task test_bouncy();
    for (int i = 0; i < 30; i++) begin
      btn_down_raw = (i >= 4) ? 1'b1 : ((i % 2) == 0);
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bouncy_model obs=%b exp=%b edge=%0d", obs, exp_v, i);
      end
      if (i < 20) begin
        checks++;
        if (down !== (i == 10) || down_level !== (i >= 10)) begin
          errors++;
          $display("FAIL bouncy_down down=%b level=%b exp_pulse=%b edge=%0d", down, down_level, (i == 10), i);
        end
      end
    end
    settle(20);
  endtask

  task test_simultaneous();
    for (int i = 0; i < 30; i++) begin
      btn_up_raw = 1; btn_down_raw = 1;
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL simul_model obs=%b exp=%b edge=%0d", obs, exp_v, i);
      end
      checks++;
      if (up !== (i == 6) || down !== 1'b0) begin
        errors++;
        $display("FAIL simul_pulses up=%b down=%b exp_up=%b exp_down=0 edge=%0d", up, down, (i == 6), i);
      end
    end
    settle(20);
  endtask

  task test_reset_mid_hold();
    for (int i = 0; i < 36; i++) begin
      btn_up_raw = 1;
      rst = (i == 12);
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rstmid_model obs=%b exp=%b edge=%0d", obs, exp_v, i);
      end
      checks++;
      if (up !== (i == 6 || i == 19 || i == 29 || i == 34)) begin
        errors++;
        $display("FAIL rstmid_up got=%b edge=%0d", up, i);
      end
      if (i == 12) begin
        checks++;
        if (obs !== 6'b0) begin
          errors++;
          $display("FAIL rstmid_cleared obs=%b exp=000000", obs);
        end
      end
    end
    rst = 0;
    settle(20);
  endtask

  task test_mid_with_up();
    for (int i = 0; i < 40; i++) begin
      btn_mid_raw = 1;
      btn_up_raw = (i >= 3 && i < 23);
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL midup_model obs=%b exp=%b edge=%0d", obs, exp_v, i);
      end
      checks++;
      if (modify !== (i == 6) || mid_level !== (i >= 6)) begin
        errors++;
        $display("FAIL midup_modify modify=%b level=%b exp_pulse=%b edge=%0d", modify, mid_level, (i == 6), i);
      end
      checks++;
      if (up !== (i == 9 || i == 19 || i == 24 || i == 29)) begin
        errors++;
        $display("FAIL midup_up got=%b edge=%0d", up, i);
      end
    end
    settle(20);
  endtask

  task test_random();
    int   rem [3];
    logic lvl [3];
    for (int b = 0; b < 3; b++) begin rem[b] = 0; lvl[b] = 0; end
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = 1'($urandom_range(0, 1));
          rem[b] = $urandom_range(1, 30);
        end
        rem[b]--;
      end
      btn_up_raw = lvl[0]; btn_down_raw = lvl[1]; btn_mid_raw = lvl[2];
      rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random_model obs=%b exp=%b cycle=%0d", obs, exp_v, i);
      end
      checks++;
      if ((up & down) !== 1'b0) begin
        errors++;
        $display("FAIL random_exclusive up=%b down=%b cycle=%0d", up, down, i);
      end
    end
    rst = 0;
    settle(20);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_glitch();
    test_bouncy();
    test_simultaneous();
    test_reset_mid_hold();
    test_mid_with_up();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
